// File: rtl/imem_responder.sv
// Instruction-fetch responder: one-stage memory read (s1) feeding a 3-entry
// in-order response FIFO, with a side port for loading the program image.
module imem_responder #(
  parameter int          DEPTH    = 256,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_instr,
  output logic [31:0]              rsp_addr,
  output logic                     rsp_err,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [31:0]              ld_data
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0] r_mem [DEPTH];

  logic        r_s1_valid;
  logic [31:0] r_s1_addr;
  logic        r_s1_err;
  logic [31:0] r_s1_rdata;

  logic [31:0] r_fifo_instr [3];
  logic [31:0] r_fifo_addr  [3];
  logic        r_fifo_err   [3];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [1:0]  r_fifo_count;

  logic [2:0]    w_occ;
  logic          w_accept;
  logic          w_req_err;
  logic [AW-1:0] w_req_idx;
  logic          w_push;
  logic          w_pop;

  // Occupancy counts the word in flight so the FIFO can always absorb it.
  assign w_occ     = {1'b0, r_fifo_count} + {2'b00, r_s1_valid};
  assign req_ready = !rst && (w_occ < 3'd3);
  assign w_accept  = req_valid && req_ready;
  assign w_req_err = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
  assign w_req_idx = req_addr[AW+1:2];

  assign w_push = r_s1_valid;
  assign w_pop  = rsp_valid && rsp_ready;

  assign rsp_valid = (r_fifo_count != 2'd0);
  assign rsp_instr = rsp_valid ? r_fifo_instr[r_rd_ptr] : 32'h0;
  assign rsp_addr  = rsp_valid ? r_fifo_addr[r_rd_ptr]  : 32'h0;
  assign rsp_err   = rsp_valid && r_fifo_err[r_rd_ptr];

  // Program load ignores reset; the read sees the pre-write word (read-first).
  always_ff @(posedge clk) begin
    if (ld_en) begin
      r_mem[ld_addr] <= ld_data;
    end
    if (w_accept) begin
      r_s1_rdata <= r_mem[w_req_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_addr    <= 32'h0;
      r_s1_err     <= 1'b0;
      r_wr_ptr     <= 2'd0;
      r_rd_ptr     <= 2'd0;
      r_fifo_count <= 2'd0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_addr <= req_addr;
        r_s1_err  <= w_req_err;
      end
      if (w_push) begin
        r_fifo_instr[r_wr_ptr] <= r_s1_err ? NOP_WORD : r_s1_rdata;
        r_fifo_addr[r_wr_ptr]  <= r_s1_addr;
        r_fifo_err[r_wr_ptr]   <= r_s1_err;
        r_wr_ptr <= (r_wr_ptr == 2'd2) ? 2'd0 : r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == 2'd2) ? 2'd0 : r_rd_ptr + 2'd1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_fifo_count <= r_fifo_count + 2'd1;
        2'b01:   r_fifo_count <= r_fifo_count - 2'd1;
        default: r_fifo_count <= r_fifo_count;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: vector table of single fetches plus
// hand-written backpressure, streaming, reset and read-first sequences.
module tb_imem_responder;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_instr;
  logic [31:0]   rsp_addr;
  logic          rsp_err;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;

  int checks;
  int failures;
  logic [31:0] exp_mem [DEPTH];

  imem_responder #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
    .rsp_addr(rsp_addr), .rsp_err(rsp_err),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic load(input int idx, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = AW'(idx); ld_data = d;
    tick();
    ld_en = 1'b0;
    exp_mem[idx] = d;
  endtask

  // Single fetch with rsp_ready=1: response must appear exactly two edges later.
  task automatic req_one(input string nm, input logic [31:0] a,
                         input logic [31:0] ei, input logic ee);
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = a;
    chk({nm, " req_ready"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0; req_addr = 32'h0;
    chk({nm, " early rsp_valid"}, 32'(rsp_valid), 32'd0);
    tick();
    chk({nm, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({nm, " rsp_instr"}, rsp_instr, ei);
    chk({nm, " rsp_addr"}, rsp_addr, a);
    chk({nm, " rsp_err"}, 32'(rsp_err), 32'(ee));
    $display("txn %s addr=%h instr=%h err=%0d", nm, rsp_addr, rsp_instr, rsp_err);
    tick();
    chk({nm, " drained"}, 32'(rsp_valid), 32'd0);
  endtask

  vec_t vecs [10];

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; rsp_ready = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = 32'h0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'hx;

    tick(); tick();
    chk("reset req_ready", 32'(req_ready), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("post-reset req_ready", 32'(req_ready), 32'd1);
    chk("post-reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post-reset rsp_instr", rsp_instr, 32'h0);
    chk("post-reset rsp_addr", rsp_addr, 32'h0);
    chk("post-reset rsp_err", 32'(rsp_err), 32'd0);

    load(0, 32'h0050_0093);
    load(1, 32'h0000_0013);
    for (int i = 2; i < DEPTH; i++) load(i, 32'hA000_0000 + 32'(i));
    load(5, 32'h1111_1111);

    vecs[0] = '{32'h0000_0000, 32'h0050_0093, 1'b0};
    vecs[1] = '{32'h0000_0004, 32'h0000_0013, 1'b0};
    vecs[2] = '{32'h0000_0002, NOP,           1'b1};
    vecs[3] = '{32'(DEPTH*4),  NOP,           1'b1};
    vecs[4] = '{32'h0000_003C, 32'hA000_000F, 1'b0};
    vecs[5] = '{32'h0000_0001, NOP,           1'b1};
    vecs[6] = '{32'hFFFF_FFFC, NOP,           1'b1};
    vecs[7] = '{32'h0000_0014, 32'h1111_1111, 1'b0};
    vecs[8] = '{32'h4000_0000, NOP,           1'b1};
    vecs[9] = '{32'h0000_0008, 32'hA000_0002, 1'b0};
    for (int i = 0; i < 10; i++)
      req_one($sformatf("vec%0d", i), vecs[i].addr, vecs[i].instr, vecs[i].err);

    // Backpressure: three acceptances fill s1+FIFO, fourth waits for a pop.
    rsp_ready = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_addr = 32'(i * 4);
      chk($sformatf("bp accept%0d ready", i), 32'(req_ready), 32'd1);
      tick();
    end
    req_addr = 32'h0000_000C;
    chk("bp full ready", 32'(req_ready), 32'd0);
    tick();
    chk("bp full ready2", 32'(req_ready), 32'd0);
    chk("bp head addr", rsp_addr, 32'h0);
    tick();
    chk("bp head stable", rsp_addr, 32'h0);
    chk("bp head instr", rsp_instr, exp_mem[0]);
    rsp_ready = 1'b1;
    chk("bp ready before pop", 32'(req_ready), 32'd0);
    tick();
    chk("bp ready after pop", 32'(req_ready), 32'd1);
    chk("bp rsp1 addr", rsp_addr, 32'h4);
    chk("bp rsp1 instr", rsp_instr, exp_mem[1]);
    tick();
    req_valid = 1'b0;
    chk("bp rsp2 addr", rsp_addr, 32'h8);
    chk("bp rsp2 instr", rsp_instr, exp_mem[2]);
    tick();
    chk("bp rsp3 valid", 32'(rsp_valid), 32'd1);
    chk("bp rsp3 addr", rsp_addr, 32'hC);
    chk("bp rsp3 instr", rsp_instr, exp_mem[3]);
    tick();
    chk("bp drained", 32'(rsp_valid), 32'd0);

    // Streaming: 16 back-to-back requests, responses on consecutive cycles.
    rsp_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) begin
        req_valid = 1'b1; req_addr = 32'(i * 4);
        chk($sformatf("stream ready%0d", i), 32'(req_ready), 32'd1);
      end else begin
        req_valid = 1'b0; req_addr = 32'h0;
      end
      if (i >= 2) begin
        chk($sformatf("stream valid%0d", i - 2), 32'(rsp_valid), 32'd1);
        chk($sformatf("stream addr%0d", i - 2), rsp_addr, 32'((i - 2) * 4));
        chk($sformatf("stream instr%0d", i - 2), rsp_instr, exp_mem[i - 2]);
      end
      tick();
    end
    chk("stream drained", 32'(rsp_valid), 32'd0);

    // Mid-stream reset with 2 queued + 1 in s1, plus a load during reset.
    rsp_ready = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_addr = 32'(i * 4);
      tick();
    end
    chk("pre-reset occupancy ready", 32'(req_ready), 32'd0);
    rst = 1'b1; rsp_ready = 1'b1;
    ld_en = 1'b1; ld_addr = AW'(7); ld_data = 32'h7777_7777;
    exp_mem[7] = 32'h7777_7777;
    tick();
    ld_en = 1'b0;
    chk("in-reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("in-reset req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0; req_valid = 1'b0;
    #1;
    chk("after-reset req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("no stale rsp%0d", i), 32'(rsp_valid), 32'd0);
    end
    req_one("reread w0", 32'h0, 32'h0050_0093, 1'b0);
    req_one("reread w3", 32'hC, 32'hA000_0003, 1'b0);
    req_one("load in reset w7", 32'h1C, 32'h7777_7777, 1'b0);

    // Read-first: load and read of word 5 on the same edge.
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h14;
    ld_en = 1'b1; ld_addr = AW'(5); ld_data = 32'hDEAD_BEEF;
    tick();
    ld_en = 1'b0; req_valid = 1'b0;
    tick();
    chk("rf old valid", 32'(rsp_valid), 32'd1);
    chk("rf old word", rsp_instr, 32'h1111_1111);
    tick();
    req_one("rf new word", 32'h14, 32'hDEAD_BEEF, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
